// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Constants and types shared by the UART blocks (uart_rx, uart_tx).
//   - Frame format: DATA_BITS data bits, LSB first, one stop bit (8N1).
//   - OVERSAMPLE baud ticks per bit. The receiver samples at the bit centre.
//   - uart_state_e: 3-bit FSM state encoding used by the receiver.
//   - majority3(): 2-of-3 vote used when majority sampling is enabled.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Tick positions inside one bit period; tick_cnt runs 0..15.
    localparam logic [3:0] SAMPLE_TICK   = 4'd7;   // centre of the bit
    localparam logic [3:0] MAJ_LAST_TICK = 4'd9;   // last of the samples at 7, 8, 9
    localparam logic [3:0] LAST_TICK     = 4'd15;  // end of the bit period

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial input. Both stages reset
//   to 1 (the idle line level) so that reset never looks like a start bit.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     i_d    in   asynchronous input (serial line)
//     o_q    out  synchronised copy of i_d, two clk later
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // NOTE: flops use non-blocking assignments so each stage captures the
    // value its predecessor held before the edge; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver driven by the shared 16x oversampling baud tick.
//   The line is synchronised, a low level on a baud tick starts a frame, every
//   bit is sampled at its centre and a good byte is delivered with a one-clk
//   done strobe. A low stop bit raises a one-clk frame-error strobe and the
//   receiver then waits for the line to return high before looking for a new
//   start bit.
//
//   Build option (macro UART_RX_MAJORITY_EN):
//     defined   - each bit is sampled at ticks 7, 8, 9 and decided by 2-of-3
//                 majority at tick 9 (done/err two ticks later).
//     undefined - single sample and decision at tick 7.
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous, active-high reset
//     i_rx         in   serial line, asynchronous to clk, idle high
//     i_baud_tick  in   one-clk pulse at 16x the baud rate
//     o_rx_data    out  last correctly framed byte, held until the next one
//     o_rx_done    out  one-clk pulse when o_rx_data is updated
//     o_rx_busy    out  high while in START, DATA or STOP
//     o_frame_err  out  one-clk pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx,
    input  logic                 i_baud_tick,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_done,
    output logic                 o_rx_busy,
    output logic                 o_frame_err
);

    import uart_pkg::*;

    // The tick counter is fixed at 4 bits, so only 16x oversampling works.
    if (OVERSAMPLE != 16 || DATA_BITS < 2) begin : g_bad_config
        $error("uart_rx: only OVERSAMPLE=16 and DATA_BITS>=2 are supported");
    end

    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_TICK = MAJ_LAST_TICK;
`else
    localparam logic [3:0] DECIDE_TICK = SAMPLE_TICK;
`endif

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    uart_state_e           state_d,    state_q;
    logic [3:0]            tick_cnt_d, tick_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d,  bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_d,    shift_q;
    logic [DATA_BITS-1:0]  data_d,     data_q;
    logic                  done_d,     done_q;
    logic                  err_d,      err_q;
    logic                  busy_d,     busy_q;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]            hist_d,     hist_q;   // samples from the two previous ticks
`endif

    // Bit value used at the decision tick.
    logic bit_val;
    // Baud tick that lands on the decision point / the end of the bit.
    logic decide_tick;
    logic last_tick;
    logic in_frame;

`ifdef UART_RX_MAJORITY_EN
    // At tick 9, hist_q[1] holds the tick-7 sample and hist_q[0] the tick-8 one.
    assign bit_val = majority3(hist_q[1], hist_q[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign decide_tick = i_baud_tick && (tick_cnt_q == DECIDE_TICK);
    assign last_tick   = i_baud_tick && (tick_cnt_q == LAST_TICK);
    assign in_frame    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold/idle value first so that no branch
        // of the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        hist_d     = hist_q;
        if (i_baud_tick && in_frame) begin
            hist_d = {hist_q[0], rx_s};
        end
`endif

        case (state_q)
            IDLE: begin
                // The tick that sees the low line is tick 0 of the start bit.
                if (i_baud_tick && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = 4'd1;
                end
            end

            START: begin
                if (i_baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (decide_tick && bit_val) begin
                        // Line went back high before mid-bit: a glitch.
                        state_d    = IDLE;
                        tick_cnt_d = 4'd0;
                    end else if (last_tick) begin
                        state_d    = DATA;
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = '0;
                    end
                end
            end

            DATA: begin
                if (i_baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;   // wraps 15 -> 0
                    if (decide_tick) begin
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};   // LSB first
                    end
                    if (last_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            STOP: begin
                // Decide at mid stop bit rather than its end, leaving half a
                // bit of slack to catch a back-to-back start edge.
                if (i_baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (decide_tick) begin
                        tick_cnt_d = 4'd0;
                        if (bit_val) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
            end

            BREAK: begin
                // Hold off start detection until the line has returned high.
                if (i_baud_tick && rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                tick_cnt_d = 4'd0;
            end
        endcase

        // Registered from the next state so busy changes together with state_q.
        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= hist_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_rx_data   = data_q;
    assign o_rx_done   = done_q;
    assign o_rx_busy   = busy_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Drives the serial line one level per baud tick and predicts the received
//   bytes / frame errors from the waveform itself: a frame starting at tick
//   index b has bit k judged at index b + 16*(k+1) + 7 (or the 2-of-3 vote of
//   indices +7, +8, +9 with UART_RX_MAJORITY_EN).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int TICK_CLKS = 54;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = 9;
`else
    localparam int DEC = 7;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       i_rx;
    logic       i_baud_tick = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_rx_busy;
    logic       o_frame_err;

    int checks = 0;
    int errors = 0;

    logic       wave[$];          // line level per baud tick
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_last = 8'h00;
    int         exp_err  = 0;
    int         got_err  = 0;
    int         busy_cycles = 0;
    int         pulse_viol  = 0;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;

    uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .i_baud_tick (i_baud_tick),
        .o_rx_data   (o_rx_data),
        .o_rx_done   (o_rx_done),
        .o_rx_busy   (o_rx_busy),
        .o_frame_err (o_frame_err)
    );

    initial forever #5 clk = ~clk;

    // One-clk baud tick every TICK_CLKS clocks, changed on the falling edge.
    initial begin
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk);
            i_baud_tick = 1'b1;
            @(negedge clk);
            i_baud_tick = 1'b0;
        end
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_rx_done) got_q.push_back(o_rx_data);
        if (o_frame_err) got_err++;
        if (o_rx_busy) busy_cycles++;
        if ((o_rx_done && prev_done) || (o_frame_err && prev_err) || (o_rx_done && o_frame_err))
            pulse_viol++;
        prev_done = o_rx_done;
        prev_err  = o_frame_err;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Returns at the falling edge right after a baud tick has been sampled.
    task automatic wait_tick();
        @(posedge clk);
        while (!i_baud_tick) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            i_rx = v;
            wait_tick();
        end
    endtask

    task automatic push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic build_frame(input logic [7:0] b, input logic stop_v);
        push_level(1'b0, 16);
        for (int k = 0; k < 8; k++) push_level(b[k], 16);
        push_level(stop_v, 16);
    endtask

    // Plays the first n wave entries (all if n < 0) and clears the wave.
    task automatic play(input int n);
        int lim;
        lim = (n < 0 || n > wave.size()) ? wave.size() : n;
        for (int i = 0; i < lim; i++) begin
            i_rx = wave[i];
            wait_tick();
        end
        wave.delete();
    endtask

    function automatic logic level_at(input int idx);
        return (idx < wave.size()) ? wave[idx] : 1'b1;
    endfunction

    // Value judged for the bit period starting at wave index base.
    function automatic logic judge(input int base);
`ifdef UART_RX_MAJORITY_EN
        int ones;
        ones = int'(level_at(base + 7)) + int'(level_at(base + 8)) + int'(level_at(base + 9));
        return ones >= 2;
`else
        return level_at(base + 7);
`endif
    endfunction

    // Predicts the outcome of a frame whose start edge is at wave index base.
    task automatic model_frame(input int base);
        logic [7:0] b;
        if (judge(base)) return;   // false start
        for (int k = 0; k < 8; k++) b[k] = judge(base + 16 * (k + 1));
        if (judge(base + 144)) begin
            exp_q.push_back(b);
            exp_last = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic compare_rx(input string tag);
        logic [7:0] g, e;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
        check({tag, "_err"}, got_err, exp_err);
        check({tag, "_held"}, o_rx_data, exp_last);
    endtask

    initial begin
        int b0;
        int cut;
        int k;
        logic [7:0] glitch_exp;

        // ---- reset state ----
        reset = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", o_rx_data, 8'h00);
        check("rst_done", o_rx_done, 1'b0);
        check("rst_busy", o_rx_busy, 1'b0);
        check("rst_err",  o_frame_err, 1'b0);
        reset = 1'b0;
        wait_tick();
        drive_level(1'b1, 2);

        // ---- valid frame 0xA5 ----
        build_frame(8'hA5, 1'b1);
        model_frame(0);
        b0 = busy_cycles;
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        check("valid_busy", busy_cycles - b0, (144 + DEC) * TICK_CLKS);
        compare_rx("valid");

        // ---- back-to-back frames, zero idle gap ----
        build_frame(8'h00, 1'b1);
        build_frame(8'hFF, 1'b1);
        build_frame(8'h3C, 1'b1);
        for (int f = 0; f < 3; f++) model_frame(160 * f);
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        compare_rx("b2b");

        // ---- 4-tick glitch ----
        push_level(1'b0, 4);
        push_level(1'b1, 8);
        model_frame(0);
        b0 = busy_cycles;
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        check("glitch_busy", busy_cycles - b0, DEC * TICK_CLKS);
        compare_rx("glitch");

        // ---- framing error, line held low afterwards ----
        build_frame(8'h55, 1'b0);
        model_frame(0);
        push_level(1'b0, 30);
        b0 = busy_cycles;
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        check("ferr_busy", busy_cycles - b0, (144 + DEC) * TICK_CLKS);
        compare_rx("ferr");

        // ---- reset during bit 3 of 0x81 ----
        build_frame(8'h81, 1'b1);
        cut = 64 + $urandom_range(0, 15);
        play(cut);
        reset = 1'b1;
        #1;
        exp_last = 8'h00;
        check("midrst_data", o_rx_data, 8'h00);
        check("midrst_done", o_rx_done, 1'b0);
        check("midrst_busy", o_rx_busy, 1'b0);
        check("midrst_err",  o_frame_err, 1'b0);
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_tick();
        drive_level(1'b1, 2);
        build_frame(8'h42, 1'b1);
        model_frame(0);
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        compare_rx("post_rst");

        // ---- one-tick low glitch inside a '1' data bit of 0xFF ----
        k = $urandom_range(0, 7);
        build_frame(8'hFF, 1'b1);
`ifdef UART_RX_MAJORITY_EN
        wave[16 * (k + 1) + 8] = 1'b0;
        glitch_exp = 8'hFF;
`else
        wave[16 * (k + 1) + 7] = 1'b0;
        glitch_exp = 8'hFF ^ (8'h01 << k);
`endif
        model_frame(0);
        play(-1);
        drive_level(1'b1, $urandom_range(1, 3));
        check("bitglitch_data", o_rx_data, glitch_exp);
        compare_rx("bitglitch");

        // ---- pulse shape over the whole run ----
        check("pulse_shape", pulse_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
